ptw_arbiter: RTL and testbench

Shares the single page-table walker between the instruction TLB and the data TLB. Accepts miss requests from both TLBs, grants one at a time with round-robin fairness, forwards the virtual address to the walker, and returns the walker's PTE only to the TLB that issued the request. Sits between the two TLBs and the `ptw` block; the walker's memory port is untouched.

---
 rtl/ptw_arbiter.sv | 142 ++++++++++++++
 tb/tb_ptw_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_arbiter.sv
// Shares one page-table walker between the ITLB and DTLB: round-robin grant,
// one walk in flight, and the PTE is routed back only to the requester that owns the walk.
module ptw_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            itlb_req_valid_i,
    output logic            itlb_req_ready_o,
    input  logic [XLEN-1:0] itlb_vaddr_i,
    output logic            itlb_resp_valid_o,
    input  logic            itlb_resp_ready_i,
    output logic [XLEN-1:0] itlb_pte_o,

    input  logic            dtlb_req_valid_i,
    output logic            dtlb_req_ready_o,
    input  logic [XLEN-1:0] dtlb_vaddr_i,
    output logic            dtlb_resp_valid_o,
    input  logic            dtlb_resp_ready_i,
    output logic [XLEN-1:0] dtlb_pte_o,

    output logic            ptw_req_valid_o,
    input  logic            ptw_req_ready_i,
    output logic [XLEN-1:0] ptw_vaddr_o,
    input  logic            ptw_resp_valid_i,
    output logic            ptw_resp_ready_o,
    input  logic [XLEN-1:0] ptw_pte_i,

    output logic            busy_o,
    output logic [1:0]      dbg_state_o
);

    // Every port pair is valid/ready: a transfer happens on the rising edge
    // where both are 1; the source holds valid and payload stable until then.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic SEL_ITLB = 1'b0;
    localparam logic SEL_DTLB = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q;
    logic              last_q;
    logic [XLEN-1:0]   vaddr_q;
    logic [XLEN-1:0]   pte_q;

    logic              win_i;
    logic              win_d;
    logic              hs_i;
    logic              hs_d;
    logic              grant;

    // Tie goes to whichever side was not granted last.
    assign win_i = itlb_req_valid_i && (!dtlb_req_valid_i || (last_q == SEL_DTLB));
    assign win_d = dtlb_req_valid_i && (!itlb_req_valid_i || (last_q == SEL_ITLB));

    assign hs_i  = (state_q == IDLE) && win_i;
    assign hs_d  = (state_q == IDLE) && win_d;
    assign grant = hs_i || hs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= SEL_ITLB;
            last_q  <= SEL_DTLB;
            vaddr_q <= '0;
            pte_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= hs_d;
                last_q  <= hs_d;
                vaddr_q <= hs_d ? dtlb_vaddr_i : itlb_vaddr_i;
            end
            if ((state_q == WAIT) && ptw_resp_valid_i) begin
                pte_q <= ptw_pte_i;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        itlb_req_ready_o  = 1'b0;
        dtlb_req_ready_o  = 1'b0;
        itlb_resp_valid_o = 1'b0;
        dtlb_resp_valid_o = 1'b0;
        ptw_req_valid_o   = 1'b0;
        ptw_resp_ready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                itlb_req_ready_o = hs_i;
                dtlb_req_ready_o = hs_d;
                if (grant) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                ptw_req_valid_o = 1'b1;
                if (ptw_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                ptw_resp_ready_o = 1'b1;
                if (ptw_resp_valid_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // A ready from the non-owner port is ignored.
                if (owner_q == SEL_ITLB) begin
                    itlb_resp_valid_o = 1'b1;
                    if (itlb_resp_ready_i) begin
                        state_d = IDLE;
                    end
                end else begin
                    dtlb_resp_valid_o = 1'b1;
                    if (dtlb_resp_ready_i) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ptw_vaddr_o = vaddr_q;
    assign itlb_pte_o  = pte_q;
    assign dtlb_pte_o  = pte_q;
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed scoreboard bench for ptw_arbiter: the bench plays both TLBs and the walker,
// pushes hand-computed expectations and checks them from an independent monitor.
module tb_ptw_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            itlb_req_valid, itlb_resp_ready;
    logic [XLEN-1:0] itlb_vaddr;
    logic            dtlb_req_valid, dtlb_resp_ready;
    logic [XLEN-1:0] dtlb_vaddr;
    logic            ptw_req_ready, ptw_resp_valid;
    logic [XLEN-1:0] ptw_pte;

    logic            itlb_req_ready_o, itlb_resp_valid_o;
    logic [XLEN-1:0] itlb_pte_o;
    logic            dtlb_req_ready_o, dtlb_resp_valid_o;
    logic [XLEN-1:0] dtlb_pte_o;
    logic            ptw_req_valid_o, ptw_resp_ready_o;
    logic [XLEN-1:0] ptw_vaddr_o;
    logic            busy_o;
    logic [1:0]      dbg_state_o;

    logic [XLEN-1:0] exp_vaddr_q[$];
    logic [XLEN-1:0] exp_i_q[$];
    logic [XLEN-1:0] exp_d_q[$];

    int checks = 0;
    int errors = 0;
    int walk_lat = 2;

    ptw_arbiter #(.XLEN(XLEN)) dut (
        .clk               (clk),
        .rst               (rst),
        .itlb_req_valid_i  (itlb_req_valid),
        .itlb_req_ready_o  (itlb_req_ready_o),
        .itlb_vaddr_i      (itlb_vaddr),
        .itlb_resp_valid_o (itlb_resp_valid_o),
        .itlb_resp_ready_i (itlb_resp_ready),
        .itlb_pte_o        (itlb_pte_o),
        .dtlb_req_valid_i  (dtlb_req_valid),
        .dtlb_req_ready_o  (dtlb_req_ready_o),
        .dtlb_vaddr_i      (dtlb_vaddr),
        .dtlb_resp_valid_o (dtlb_resp_valid_o),
        .dtlb_resp_ready_i (dtlb_resp_ready),
        .dtlb_pte_o        (dtlb_pte_o),
        .ptw_req_valid_o   (ptw_req_valid_o),
        .ptw_req_ready_i   (ptw_req_ready),
        .ptw_vaddr_o       (ptw_vaddr_o),
        .ptw_resp_valid_i  (ptw_resp_valid),
        .ptw_resp_ready_o  (ptw_resp_ready_o),
        .ptw_pte_i         (ptw_pte),
        .busy_o            (busy_o),
        .dbg_state_o       (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout, got 0x0, expected 0x1", name);
    endtask

    // Walker model: PTE table of hand-picked values, other addresses get vaddr | 0xF.
    function automatic logic [XLEN-1:0] pte_for(input logic [XLEN-1:0] va);
        case (va)
            32'h0000_1000: pte_for = 32'h1100_000F;
            32'h0000_0000: pte_for = 32'h1000_000F;
            32'h0000_2000: pte_for = 32'h1200_0007;
            32'h8000_0000: pte_for = 32'h0000_0000;
            default:       pte_for = va | 32'h0000_000F;
        endcase
    endfunction

    initial begin
        logic [XLEN-1:0] wv;
        logic            aborted;
        ptw_req_ready  = 1'b0;
        ptw_resp_valid = 1'b0;
        ptw_pte        = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst && ptw_req_valid_o) begin
                ptw_req_ready = 1'b1;
                wv = ptw_vaddr_o;
                @(posedge clk); #1;
                ptw_req_ready = 1'b0;
                aborted = 1'b0;
                for (int k = 0; k < walk_lat; k++) begin
                    if (rst) aborted = 1'b1;
                    @(posedge clk); #1;
                end
                if (rst) aborted = 1'b1;
                if (!aborted) begin
                    ptw_resp_valid = 1'b1;
                    ptw_pte        = pte_for(wv);
                    @(posedge clk); #1;
                    ptw_resp_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (ptw_req_valid_o && ptw_req_ready) begin
            if (exp_vaddr_q.size() == 0) fail_timeout("ptw_vaddr_unexpected");
            else check("ptw_vaddr", ptw_vaddr_o, exp_vaddr_q.pop_front());
        end
        if (itlb_resp_valid_o && itlb_resp_ready) begin
            if (exp_i_q.size() == 0) fail_timeout("itlb_resp_spurious");
            else check("itlb_pte", itlb_pte_o, exp_i_q.pop_front());
        end
        if (dtlb_resp_valid_o && dtlb_resp_ready) begin
            if (exp_d_q.size() == 0) fail_timeout("dtlb_resp_spurious");
            else check("dtlb_pte", dtlb_pte_o, exp_d_q.pop_front());
        end
        if (itlb_resp_valid_o && dtlb_resp_valid_o)
            check("both_resp_valid", 32'(dtlb_resp_valid_o), 32'h0);
        if (itlb_req_ready_o && dtlb_req_ready_o)
            check("both_req_ready", 32'(dtlb_req_ready_o), 32'h0);
        if (busy_o && (itlb_req_ready_o || dtlb_req_ready_o))
            check("req_ready_while_busy", {30'h0, itlb_req_ready_o, dtlb_req_ready_o}, 32'h0);
    end

    // ---------------- driver tasks ----------------
    task automatic issue_i(input logic [XLEN-1:0] va, input bit chk_now);
        bit got = 0;
        itlb_req_valid = 1'b1;
        itlb_vaddr     = va;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (chk_now && c == 0) check("itlb_ready_same_cycle", 32'(itlb_req_ready_o), 32'h1);
            if (itlb_req_ready_o) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_timeout("itlb_grant");
        @(posedge clk); #1;
        itlb_req_valid = 1'b0;
        itlb_vaddr     = '0;
    endtask

    task automatic issue_d(input logic [XLEN-1:0] va);
        bit got = 0;
        dtlb_req_valid = 1'b1;
        dtlb_vaddr     = va;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (dtlb_req_ready_o) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_timeout("dtlb_grant");
        @(posedge clk); #1;
        dtlb_req_valid = 1'b0;
        dtlb_vaddr     = '0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (exp_vaddr_q.size() == 0 && exp_i_q.size() == 0 && exp_d_q.size() == 0 && !busy_o) begin
                done = 1;
                break;
            end
        end
        if (!done) fail_timeout(name);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        itlb_req_valid  = 1'b0;
        itlb_vaddr      = '0;
        itlb_resp_ready = 1'b1;
        dtlb_req_valid  = 1'b0;
        dtlb_vaddr      = '0;
        dtlb_resp_ready = 1'b1;
        do_reset();

        @(negedge clk);
        check("rst_itlb_req_ready", 32'(itlb_req_ready_o), 32'h0);
        check("rst_dtlb_req_ready", 32'(dtlb_req_ready_o), 32'h0);
        check("rst_ptw_req_valid", 32'(ptw_req_valid_o), 32'h0);
        check("rst_itlb_resp_valid", 32'(itlb_resp_valid_o), 32'h0);
        check("rst_dtlb_resp_valid", 32'(dtlb_resp_valid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_ptw_vaddr", ptw_vaddr_o, 32'h0);
        check("rst_pte", itlb_pte_o, 32'h0);
        @(posedge clk); #1;

        // ITLB alone
        exp_vaddr_q.push_back(32'h0000_1000);
        exp_i_q.push_back(32'h1100_000F);
        issue_i(32'h0000_1000, 1'b1);
        wait_drain("drain_itlb_only");

        // Tie from reset: ITLB first, then DTLB
        do_reset();
        exp_vaddr_q.push_back(32'h0000_0000);
        exp_vaddr_q.push_back(32'h0000_2000);
        exp_i_q.push_back(32'h1000_000F);
        exp_d_q.push_back(32'h1200_0007);
        fork
            issue_i(32'h0000_0000, 1'b0);
            issue_d(32'h0000_2000);
        join
        wait_drain("drain_tie");

        // Both held valid: grants alternate I, D, I, D
        exp_vaddr_q.push_back(32'h0000_3000);
        exp_vaddr_q.push_back(32'h0000_4000);
        exp_vaddr_q.push_back(32'h0000_7000);
        exp_vaddr_q.push_back(32'h0000_8000);
        exp_i_q.push_back(32'h0000_300F);
        exp_i_q.push_back(32'h0000_700F);
        exp_d_q.push_back(32'h0000_400F);
        exp_d_q.push_back(32'h0000_800F);
        fork
            begin
                issue_i(32'h0000_3000, 1'b0);
                issue_i(32'h0000_7000, 1'b0);
            end
            begin
                issue_d(32'h0000_4000);
                issue_d(32'h0000_8000);
            end
        join
        wait_drain("drain_alternate");

        // DTLB stalls its response; invalid PTE forwarded; no new grant meanwhile
        dtlb_resp_ready = 1'b0;
        exp_vaddr_q.push_back(32'h8000_0000);
        exp_d_q.push_back(32'h0000_0000);
        issue_d(32'h8000_0000);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dtlb_resp_valid_o) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_timeout("dtlb_resp_valid");
        @(posedge clk); #1;
        exp_vaddr_q.push_back(32'h0000_9000);
        exp_i_q.push_back(32'h0000_900F);
        fork
            issue_i(32'h0000_9000, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("hold_dtlb_resp_valid", 32'(dtlb_resp_valid_o), 32'h1);
                    check("hold_dtlb_pte", dtlb_pte_o, 32'h0000_0000);
                    check("hold_no_grant", 32'(itlb_req_ready_o), 32'h0);
                end
                @(posedge clk); #1;
                dtlb_resp_ready = 1'b1;
            end
        join
        wait_drain("drain_hold");

        // Reset while the walk is outstanding
        walk_lat = 10;
        exp_vaddr_q.push_back(32'h0000_5000);
        exp_i_q.push_back(32'h0000_500F);
        issue_i(32'h0000_5000, 1'b0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dbg_state_o == 2'd2) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_timeout("reach_wait");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("wrst_state", 32'(dbg_state_o), 32'h0);
        check("wrst_busy", 32'(busy_o), 32'h0);
        check("wrst_ptw_req_valid", 32'(ptw_req_valid_o), 32'h0);
        check("wrst_ptw_resp_ready", 32'(ptw_resp_ready_o), 32'h0);
        check("wrst_itlb_resp_valid", 32'(itlb_resp_valid_o), 32'h0);
        check("wrst_ptw_vaddr", ptw_vaddr_o, 32'h0);
        check("wrst_pte", itlb_pte_o, 32'h0);
        rst = 1'b0;
        exp_i_q.delete();
        walk_lat = 2;
        @(posedge clk); #1;
        exp_vaddr_q.push_back(32'h0000_6000);
        exp_i_q.push_back(32'h0000_600F);
        issue_i(32'h0000_6000, 1'b0);
        wait_drain("drain_after_reset");

        check("left_vaddr", 32'(exp_vaddr_q.size()), 32'h0);
        check("left_itlb", 32'(exp_i_q.size()), 32'h0);
        check("left_dtlb", 32'(exp_d_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
